// File: rtl/systolic_result_drain.sv
// Result drain for the systolic multiplier: captures the M x P accumulator frame on done,
// then streams each element row-major over valid/ready, requantized by rounding shift and saturation.
module systolic_result_drain #(
  parameter int M            = 8,
  parameter int P            = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int OUT_WIDTH    = 8,
  localparam int ROW_W       = (M > 1) ? $clog2(M) : 1,
  localparam int COL_W       = (P > 1) ? $clog2(P) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           done,
  input  logic [M*P*RESULT_WIDTH-1:0]    result_c,
  input  logic [3:0]                     shift,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [OUT_WIDTH-1:0]           m_data,
  output logic                           m_sat,
  output logic                           m_last,
  output logic [ROW_W-1:0]               m_row,
  output logic [COL_W-1:0]               m_col,
  output logic                           busy,
  output logic                           overrun
);

  localparam int N     = M * P;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int XW    = RESULT_WIDTH + 1;
  localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = XW'(-(1 << (OUT_WIDTH - 1)));

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                   state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [3:0]               shift_q;
  logic                     overrun_q, overrun_d;
  logic                     load;
  logic                     handshake;
  logic                     last_elem;
  logic signed [RESULT_WIDTH-1:0] buf_q [N];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
      if (load) shift_q <= shift;
    end
  end

  // NOTE: the frame buffer is deliberately not reset; it is only read after a load has filled it.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= result_c[i*RESULT_WIDTH +: RESULT_WIDTH];
      end
    end
  end

  assign m_valid   = (state_q == STREAM);
  assign busy      = m_valid;
  assign overrun   = overrun_q;
  assign handshake = m_valid & m_ready;
  assign last_elem = (row_q == ROW_W'(M - 1)) && (col_q == COL_W'(P - 1));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done) begin
          load    = 1'b1;
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
        end
      end
      STREAM: begin
        if (handshake && last_elem) begin
          // A done coinciding with the final handshake starts the next frame back-to-back.
          row_d = '0;
          col_d = '0;
          if (done) load = 1'b1;
          else      state_d = IDLE;
        end else begin
          if (done) overrun_d = 1'b1;
          if (handshake) begin
            if (col_q == COL_W'(P - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [IDX_W-1:0]               flat_idx;
  logic signed [RESULT_WIDTH-1:0] x;
  logic signed [XW-1:0]           x_ext, rnd, y;
  logic [OUT_WIDTH-1:0]           data_c;
  logic                           sat_c;

  assign flat_idx = IDX_W'(row_q) * IDX_W'(P) + IDX_W'(col_q);
  assign x        = buf_q[flat_idx];

  // One extra bit of headroom keeps x + 2^(s-1) from overflowing before the shift.
  always_comb begin
    x_ext  = XW'(x);
    rnd    = '0;
    if (shift_q != 4'd0) rnd = XW'(1) << (shift_q - 4'd1);
    y      = (x_ext + rnd) >>> shift_q;
    sat_c  = 1'b0;
    data_c = y[OUT_WIDTH-1:0];
    if (y > SAT_MAX) begin
      data_c = SAT_MAX[OUT_WIDTH-1:0];
      sat_c  = 1'b1;
    end else if (y < SAT_MIN) begin
      data_c = SAT_MIN[OUT_WIDTH-1:0];
      sat_c  = 1'b1;
    end
  end

  assign m_data = m_valid ? data_c : '0;
  assign m_sat  = m_valid & sat_c;
  assign m_last = m_valid & last_elem;
  assign m_row  = row_q;
  assign m_col  = col_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: vector table for requantization plus
// a scoreboard checking every streamed element, with backpressure, overrun, back-to-back and reset sequences.
module tb_systolic_result_drain;

  localparam int M  = 8;
  localparam int P  = 8;
  localparam int RW = 16;
  localparam int OW = 8;
  localparam int N  = M * P;

  logic              clk;
  logic              rst;
  logic              done;
  logic [N*RW-1:0]   result_c;
  logic [3:0]        shift;
  logic              m_valid;
  logic              m_ready;
  logic [OW-1:0]     m_data;
  logic              m_sat;
  logic              m_last;
  logic [2:0]        m_row;
  logic [2:0]        m_col;
  logic              busy;
  logic              overrun;

  systolic_result_drain #(.M(M), .P(P), .RESULT_WIDTH(RW), .OUT_WIDTH(OW)) dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .result_c (result_c),
    .shift    (shift),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sat    (m_sat),
    .m_last   (m_last),
    .m_row    (m_row),
    .m_col    (m_col),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          sat;
    logic          last;
    logic [2:0]    row;
    logic [2:0]    col;
  } exp_t;

  typedef struct {
    int            x;
    int            s;
    logic [OW-1:0] exp_data;
    logic          exp_sat;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb_q[$];
  logic [N*RW-1:0] frame;
  logic [3:0]    bp_pat = 4'b1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference requantizer: real-valued floor division, independent of shifter arithmetic.
  function automatic exp_t model(input int x, input int s, input int idx);
    exp_t e;
    real  scale;
    int   y;
    scale = 1.0;
    for (int i = 0; i < s; i++) scale = scale * 2.0;
    if (s == 0) y = x;
    else        y = int'($floor((real'(x) + scale / 2.0) / scale));
    e.sat = (y > 127) || (y < -128);
    if (y > 127)       y = 127;
    else if (y < -128) y = -128;
    e.data = y[OW-1:0];
    e.row  = 3'(idx / P);
    e.col  = 3'(idx % P);
    e.last = (idx == N - 1);
    return e;
  endfunction

  task automatic push_frame(input int s);
    int x;
    for (int idx = 0; idx < N; idx++) begin
      x = int'($signed(frame[idx*RW +: RW]));
      sb_q.push_back(model(x, s, idx));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done(input bit push, input int s);
    shift    = 4'(s);
    result_c = frame;
    done     = 1'b1;
    if (push) push_frame(s);
    step();
    done     = 1'b0;
  endtask

  task automatic drain(input bit bp, output int cyc);
    cyc = 0;
    for (int i = 0; i < 4000; i++) begin
      m_ready = bp ? bp_pat[i % 4] : 1'b1;
      step();
      cyc++;
      if (sb_q.size() == 0) break;
    end
    check("drain_complete", 32'(sb_q.size()), 32'd0);
    m_ready = 1'b1;
  endtask

  task automatic identity_frame();
    for (int k = 0; k < N; k++) frame[k*RW +: RW] = 16'(k);
  endtask

  task automatic random_frame();
    for (int k = 0; k < N; k++) frame[k*RW +: RW] = 16'($urandom_range(0, 65535));
  endtask

  // Output monitor: scoreboard pop on each handshake, stability check across stalls.
  exp_t          mon_e;
  bit            have_hold = 1'b0;
  logic [OW-1:0] hold_data;
  logic [2:0]    hold_row, hold_col;

  always @(negedge clk) begin
    if (rst) begin
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        check("stall_data", 32'(m_data), 32'(hold_data));
        check("stall_row",  32'(m_row),  32'(hold_row));
        check("stall_col",  32'(m_col),  32'(hold_col));
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_data", 32'(m_data), 32'(mon_e.data));
          check("sb_sat",  32'(m_sat),  32'(mon_e.sat));
          check("sb_last", 32'(m_last), 32'(mon_e.last));
          check("sb_row",  32'(m_row),  32'(mon_e.row));
          check("sb_col",  32'(m_col),  32'(mon_e.col));
        end
      end
      have_hold = m_valid && !m_ready;
      hold_data = m_data;
      hold_row  = m_row;
      hold_col  = m_col;
    end
  end

  vec_t vecs[12];
  int   cyc;
  int   tmp;

  initial begin
    vecs[0]  = '{300,    0, 8'h7F, 1'b1};
    vecs[1]  = '{-300,   0, 8'h80, 1'b1};
    vecs[2]  = '{127,    0, 8'h7F, 1'b0};
    vecs[3]  = '{-128,   0, 8'h80, 1'b0};
    vecs[4]  = '{-129,   0, 8'h80, 1'b1};
    vecs[5]  = '{6,      2, 8'h02, 1'b0};
    vecs[6]  = '{5,      2, 8'h01, 1'b0};
    vecs[7]  = '{-7,     2, 8'hFE, 1'b0};
    vecs[8]  = '{-7,     1, 8'hFD, 1'b0};
    vecs[9]  = '{-1,     1, 8'h00, 1'b0};
    vecs[10] = '{255,    1, 8'h7F, 1'b1};
    vecs[11] = '{-32768, 15, 8'hFF, 1'b0};

    rst      = 1'b1;
    done     = 1'b0;
    m_ready  = 1'b0;
    shift    = 4'd0;
    result_c = '0;
    frame    = '0;

    // Reset state
    repeat (3) step();
    check("rst_valid",   32'(m_valid), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data",    32'(m_data),  32'd0);
    check("rst_sat",     32'(m_sat),   32'd0);
    check("rst_last",    32'(m_last),  32'd0);
    check("rst_row",     32'(m_row),   32'd0);
    check("rst_col",     32'(m_col),   32'd0);
    rst = 1'b0;
    step();
    check("idle_valid", 32'(m_valid), 32'd0);

    // Identity frame at full rate
    m_ready = 1'b1;
    identity_frame();
    pulse_done(1'b1, 0);
    check("lat_valid", 32'(m_valid), 32'd1);
    check("lat_row",   32'(m_row),   32'd0);
    check("lat_col",   32'(m_col),   32'd0);
    check("lat_data",  32'(m_data),  32'd0);
    drain(1'b0, cyc);
    check("frame_cycles", 32'(cyc),     32'd64);
    check("valid_fall",   32'(m_valid), 32'd0);
    check("busy_fall",    32'(busy),    32'd0);

    // Requantization vectors on element (0,0)
    for (int i = 0; i < 12; i++) begin
      frame = '0;
      tmp   = vecs[i].x;
      frame[RW-1:0] = tmp[RW-1:0];
      pulse_done(1'b1, vecs[i].s);
      check("vec_data", 32'(m_data), 32'(vecs[i].exp_data));
      check("vec_sat",  32'(m_sat),  32'(vecs[i].exp_sat));
      drain(1'b0, cyc);
    end

    // Backpressure with ready pattern 1,0,0,1
    identity_frame();
    pulse_done(1'b1, 0);
    drain(1'b1, cyc);
    check("bp_valid_fall", 32'(m_valid), 32'd0);

    // Overrun: second done at element 10 is dropped
    random_frame();
    pulse_done(1'b1, 3);
    repeat (10) step();
    check("ovr_at_elem10", 32'(m_col) + 32'(m_row) * 8, 32'd10);
    random_frame();
    pulse_done(1'b0, 5);
    check("ovr_set", 32'(overrun), 32'd1);
    drain(1'b0, cyc);
    check("ovr_valid_fall", 32'(m_valid), 32'd0);
    repeat (3) step();
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_idle",   32'(busy),    32'd0);

    // Mid-frame reset at element 20
    identity_frame();
    pulse_done(1'b1, 0);
    repeat (20) step();
    check("mid_at_elem20", 32'(m_data), 32'd20);
    rst = 1'b1;
    step();
    check("mid_rst_valid",   32'(m_valid), 32'd0);
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_row",     32'(m_row),   32'd0);
    check("mid_rst_col",     32'(m_col),   32'd0);
    sb_q.delete();
    rst = 1'b0;
    step();
    random_frame();
    pulse_done(1'b1, 1);
    check("restart_valid", 32'(m_valid), 32'd1);
    check("restart_row",   32'(m_row),   32'd0);
    check("restart_col",   32'(m_col),   32'd0);
    drain(1'b0, cyc);

    // Back-to-back: second done on the final handshake
    identity_frame();
    pulse_done(1'b1, 0);
    repeat (63) step();
    check("b2b_last_shown", 32'(m_last), 32'd1);
    random_frame();
    pulse_done(1'b1, 2);
    check("b2b_valid",   32'(m_valid), 32'd1);
    check("b2b_row",     32'(m_row),   32'd0);
    check("b2b_col",     32'(m_col),   32'd0);
    check("b2b_overrun", 32'(overrun), 32'd0);
    drain(1'b0, cyc);
    check("b2b_cycles",     32'(cyc),     32'd64);
    check("b2b_valid_fall", 32'(m_valid), 32'd0);
    check("b2b_overrun_end", 32'(overrun), 32'd0);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
